uart_tx_packetizer: RTL and testbench
=====================================

Name: uart_tx_packetizer

Overview:
Upstream stage of the UART TX path. Accepts one multi-byte result word (e.g. a CORDIC output) over a valid/ready handshake and frames it as a byte stream: header, then payload bytes, then an optional XOR checksum. Bytes are written one per cycle into the TX byte FIFO that the UART transmitter drains. The block never writes while the FIFO reports full.

Parameters:
NUM_BYTES, 4, payload bytes per word; legal range 1-8.
HEADER_BYTE, 8'hA5, constant first byte of every frame.
CHECKSUM_ON, 1, 1: append checksum byte; 0: frame ends after the last payload byte.
LSB_FIRST, 0, 0: payload sent most-significant byte first; 1: least-significant byte first.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_data  input  8*NUM_BYTES  payload word
i_valid  input  1  i_data valid
o_ready  output  1  block can accept a word
i_fifo_full  input  1  TX FIFO full
o_fifo_wr_en  output  1  FIFO write strobe
o_fifo_wr_data  output  8  FIFO write byte
o_busy  output  1  frame in progress

Behaviour:
- Reset: i_rst_n is synchronous and active-low, sampled on i_clk. Reset forces state IDLE, clears the byte index, the checksum accumulator and the word register.
- Reset output values: o_ready=1, o_busy=0, o_fifo_wr_en=0, o_fifo_wr_data=0.
- Reset mid-frame aborts the frame. No further writes occur, and the partial frame is not completed.
- States: IDLE, HEADER, PAYLOAD, CHECK.
- IDLE:
  - o_ready=1, o_busy=0, o_fifo_wr_en=0.
  - A word is accepted on a cycle where i_valid && o_ready. The word is latched, the checksum is set to HEADER_BYTE and the index is set to 0. Next state: HEADER.
- Outside IDLE: o_ready=0 and o_busy=1. i_data and i_valid are ignored.
- Write qualification: o_fifo_wr_en = (state != IDLE) && !i_fifo_full. It is combinational from registered state.
- o_fifo_wr_data is combinational from registered state: the current byte (header, selected payload byte, or checksum). It is held stable while stalled.
- A state or index advances only on a cycle where o_fifo_wr_en=1.
- HEADER: writes HEADER_BYTE, then moves to PAYLOAD.
- PAYLOAD:
  - Writes byte[idx]. With LSB_FIRST=0, idx 0 selects bits [8*NUM_BYTES-1 -: 8]. With LSB_FIRST=1, idx 0 selects bits [7:0].
  - On each write: checksum ^= the byte, idx++.
  - On the write with idx==NUM_BYTES-1: idx is cleared. Next state is CHECK if CHECKSUM_ON=1, otherwise IDLE.
- CHECK: writes the checksum (XOR of the header and all payload bytes), then moves to IDLE.
- Index register width: max(1, $clog2(NUM_BYTES)). NUM_BYTES=1 is legal.
- Latency and throughput:
  - Header write occurs the cycle after acceptance if the FIFO is not full.
  - An unstalled frame spans NUM_BYTES+1+CHECKSUM_ON write cycles.
  - The next accept is possible one cycle after the last write, so there is exactly one IDLE cycle between frames.
- Full/stall: while i_fifo_full=1, no write occurs and state, index, data and checksum hold. The stream resumes unchanged when full deasserts. There is no stall timeout.
- Simultaneous events: full deasserting on the last-byte cycle writes that byte and enters IDLE normally. i_valid asserted while busy is not accepted; the upstream source must hold it until o_ready is high.
- Illegal or unreachable state: return to IDLE with reset values.

Test Plan:
- Basic frame: defaults, i_data=32'h12345678 with i_valid for one cycle, FIFO never full -> writes A5,12,34,56,78,AD on 6 consecutive cycles starting the cycle after accept; o_ready=0 throughout; o_ready=1 the cycle after the AD write.
- LSB_FIRST=1, same data -> writes A5,78,56,34,12,AD.
- CHECKSUM_ON=0, same data -> writes A5,12,34,56,78, then IDLE; no sixth write.
- Stall: i_fifo_full=1 for 3 cycles while byte 34 is pending -> o_fifo_wr_en=0 for those 3 cycles, o_fifo_wr_data holds 34; the final sequence is still A5,12,34,56,78,AD with no duplicate or dropped byte.
- Back-to-back: i_valid held high with 32'h12345678 then 32'h00000001 -> second word accepted exactly one cycle after the first AD write; second frame writes A5,00,00,00,01,A4.
- Reset mid-frame: assert i_rst_n=0 for 1 cycle right after the 34 write -> no further writes; o_ready=1 and o_busy=0 on the first cycle after reset releases; a new word produces a complete, correct frame starting with A5.

Source files
------------

// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: frames one multi-byte result word as
// header, payload bytes and an optional XOR checksum, pushing one byte per
// cycle into the UART TX byte FIFO and never writing while it is full.
module uart_tx_packetizer #(
  parameter int         NUM_BYTES   = 4,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter bit         CHECKSUM_ON = 1'b1,
  parameter bit         LSB_FIRST   = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [8*NUM_BYTES-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_fifo_full,
  output logic                   o_fifo_wr_en,
  output logic [7:0]             o_fifo_wr_data,
  output logic                   o_busy
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECK
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_next;
  logic [7:0]             csum;
  logic [7:0]             csum_next;
  logic [8*NUM_BYTES-1:0] word;
  logic [8*NUM_BYTES-1:0] word_next;
  logic [7:0]             payload_byte;
  logic                   can_write;

  // A byte may only leave when the FIFO has room; a cycle held in reset never
  // writes, so a frame interrupted by reset is cut off immediately.
  assign can_write = i_rst_n && !i_fifo_full;

  // Pick the payload byte addressed by idx, honouring the byte order.
  always_comb begin
    payload_byte = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        if (LSB_FIRST) begin
          payload_byte = word[8*i +: 8];
        end else begin
          payload_byte = word[8*(NUM_BYTES-1-i) +: 8];
        end
      end
    end
  end

  // Next-state and output decode; everything advances only on a real write.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    csum_next      = csum;
    word_next      = word;
    o_ready        = 1'b0;
    o_busy         = 1'b1;
    o_fifo_wr_en   = 1'b0;
    o_fifo_wr_data = 8'h00;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_valid) begin
          word_next  = i_data;
          csum_next  = HEADER_BYTE;
          idx_next   = '0;
          state_next = HEADER;
        end
      end
      HEADER: begin
        o_fifo_wr_data = HEADER_BYTE;
        o_fifo_wr_en   = can_write;
        if (can_write) begin
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        o_fifo_wr_data = payload_byte;
        o_fifo_wr_en   = can_write;
        if (can_write) begin
          csum_next = csum ^ payload_byte;
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            state_next = CHECKSUM_ON ? CHECK : IDLE;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      CHECK: begin
        o_fifo_wr_data = csum;
        o_fifo_wr_en   = can_write;
        if (can_write) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        csum_next  = 8'h00;
        word_next  = '0;
        o_ready    = 1'b1;
        o_busy     = 1'b0;
      end
    endcase
  end

  // State, index, checksum and word registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx   <= '0;
      csum  <= 8'h00;
      word  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      csum  <= csum_next;
      word  <= word_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// tb_uart_tx_packetizer: four packetizer variants (default, LSB first,
// no checksum, single byte) driven by directed and random frames and
// compared against a byte-list model of the frame format.
module tb_uart_tx_packetizer;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        full  = 1'b0;
  logic [31:0] data  = '0;
  logic [3:0]  valid = '0;
  int          sel   = 0;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  int          stray = 0;

  wire  [3:0]  rdy;
  wire  [3:0]  bsy;
  wire  [3:0]  wen;
  wire  [7:0]  wd0, wd1, wd2, wd3;

  logic        rdy_s, bsy_s, wen_s;
  logic [7:0]  wd_s;
  logic [7:0]  got[$];
  logic [7:0]  exp[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_packetizer dut_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid[0]),
    .o_ready(rdy[0]), .i_fifo_full(full), .o_fifo_wr_en(wen[0]),
    .o_fifo_wr_data(wd0), .o_busy(bsy[0]));

  uart_tx_packetizer #(.LSB_FIRST(1'b1)) dut_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid[1]),
    .o_ready(rdy[1]), .i_fifo_full(full), .o_fifo_wr_en(wen[1]),
    .o_fifo_wr_data(wd1), .o_busy(bsy[1]));

  uart_tx_packetizer #(.CHECKSUM_ON(1'b0)) dut_nock (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid[2]),
    .o_ready(rdy[2]), .i_fifo_full(full), .o_fifo_wr_en(wen[2]),
    .o_fifo_wr_data(wd2), .o_busy(bsy[2]));

  uart_tx_packetizer #(.NUM_BYTES(1)) dut_one (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[7:0]), .i_valid(valid[3]),
    .o_ready(rdy[3]), .i_fifo_full(full), .o_fifo_wr_en(wen[3]),
    .o_fifo_wr_data(wd3), .o_busy(bsy[3]));

  // View of whichever variant the current test is exercising.
  always_comb begin
    rdy_s = rdy[0]; bsy_s = bsy[0]; wen_s = wen[0]; wd_s = wd0;
    case (sel)
      1: begin rdy_s = rdy[1]; bsy_s = bsy[1]; wen_s = wen[1]; wd_s = wd1; end
      2: begin rdy_s = rdy[2]; bsy_s = bsy[2]; wen_s = wen[2]; wd_s = wd2; end
      3: begin rdy_s = rdy[3]; bsy_s = bsy[3]; wen_s = wen[3]; wd_s = wd3; end
      default: ;
    endcase
  end

  // FIFO side: record every byte the selected variant writes; any write by
  // an idle, unselected variant is stray.
  always @(negedge clk) begin
    if (wen_s) got.push_back(wd_s);
    for (int k = 0; k < 4; k++) if (wen[k] && k != sel) stray++;
  end

  // Reference: append the byte list of one frame for variant s.
  task automatic expect_frame(input int s, input logic [31:0] w);
    int nb, pos;
    logic [7:0] c, b;
    nb = (s == 3) ? 1 : 4;
    c  = 8'hA5;
    exp.push_back(8'hA5);
    for (int i = 0; i < nb; i++) begin
      pos = (s == 1) ? i : nb - 1 - i;
      b   = w[pos*8 +: 8];
      exp.push_back(b);
      c = c ^ b;
    end
    if (s != 2) exp.push_back(c);
  endtask

  // Cycle-exact frame: accept, then one byte per cycle, then ready again.
  task automatic frame_exact(input int s, input logic [31:0] w, input string nm);
    exp.delete();
    expect_frame(s, w);
    @(posedge clk); #1;
    sel = s; data = w; valid[s] = 1'b1;
    @(negedge clk);
    total++;
    if (rdy_s !== 1'b1) begin bad++; $display("FAIL %s accept_ready got=%b want=1", nm, rdy_s); end
    @(posedge clk); #1;
    valid[s] = 1'b0;
    for (int j = 0; j < exp.size(); j++) begin
      @(negedge clk);
      total++;
      if (wen_s !== 1'b1 || wd_s !== exp[j]) begin
        bad++; $display("FAIL %s byte%0d got=%b/%h want=1/%h", nm, j, wen_s, wd_s, exp[j]);
      end
      total++;
      if (rdy_s !== 1'b0 || bsy_s !== 1'b1) begin
        bad++; $display("FAIL %s busy%0d got rdy=%b busy=%b want 0/1", nm, j, rdy_s, bsy_s);
      end
    end
    @(negedge clk);
    total++;
    if (rdy_s !== 1'b1 || bsy_s !== 1'b0 || wen_s !== 1'b0) begin
      bad++; $display("FAIL %s end_idle got rdy=%b busy=%b wen=%b want 1/0/0", nm, rdy_s, bsy_s, wen_s);
    end
  endtask

  task automatic compare_stream(input string nm);
    total++;
    if (got.size() !== exp.size()) begin
      bad++; $display("FAIL %s length got=%0d want=%0d", nm, got.size(), exp.size());
    end else begin
      for (int j = 0; j < exp.size(); j++) begin
        total++;
        if (got[j] !== exp[j]) begin
          bad++; $display("FAIL %s stream%0d got=%h want=%h", nm, j, got[j], exp[j]);
        end
      end
    end
  endtask

  task automatic drain(input int limit);
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (rdy_s && got.size() >= exp.size()) break;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (wen !== 4'h0) begin bad++; $display("FAIL reset_held_wen got=%b want=0000", wen); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rdy !== 4'hF) begin bad++; $display("FAIL reset_ready got=%b want=1111", rdy); end
    total++;
    if (bsy !== 4'h0 || wen !== 4'h0) begin
      bad++; $display("FAIL reset_busy_wen got=%b/%b want=0000/0000", bsy, wen);
    end
    total++;
    if (wd0 !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h want=00", wd0); end
  endtask

  task automatic test_stall;
    got.delete(); exp.delete();
    expect_frame(0, 32'h12345678);
    @(posedge clk); #1;
    sel = 0; data = 32'h12345678; valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (got.size() >= 2) break;
      @(posedge clk); #1;
    end
    full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (wen_s !== 1'b0 || wd_s !== 8'h34) begin
        bad++; $display("FAIL stall%0d got wen=%b data=%h want 0/34", i, wen_s, wd_s);
      end
      @(posedge clk);
    end
    #1 full = 1'b0;
    drain(40);
    compare_stream("stall");
  endtask

  task automatic test_back_to_back;
    int acc[2];
    int nacc;
    got.delete(); exp.delete();
    expect_frame(0, 32'h12345678);
    expect_frame(0, 32'h00000001);
    @(posedge clk); #1;
    sel = 0; data = 32'h12345678; valid[0] = 1'b1; nacc = 0;
    for (int c = 0; c < 60 && nacc < 2; c++) begin
      @(negedge clk);
      if (rdy_s) begin acc[nacc] = cyc; nacc++; end
      @(posedge clk); #1;
      if (nacc == 1) data = 32'h00000001;
    end
    valid[0] = 1'b0;
    drain(40);
    total++;
    if (nacc !== 2) begin
      bad++; $display("FAIL b2b_accepts got=%0d want=2", nacc);
    end else begin
      total++;
      if (acc[1] - acc[0] !== 7) begin
        bad++; $display("FAIL b2b_spacing got=%0d want=7", acc[1] - acc[0]);
      end
    end
    compare_stream("b2b");
  endtask

  task automatic test_reset_mid_frame;
    int n;
    got.delete(); exp.delete();
    expect_frame(0, 32'h12345678);
    @(posedge clk); #1;
    sel = 0; data = 32'h12345678; valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (got.size() >= 3) break;
      @(posedge clk); #1;
    end
    n = got.size();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (wen_s !== 1'b0) begin bad++; $display("FAIL rstmid_held_wen got=%b want=0", wen_s); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rdy_s !== 1'b1 || bsy_s !== 1'b0 || wd_s !== 8'h00) begin
      bad++; $display("FAIL rstmid_idle got rdy=%b busy=%b data=%h want 1/0/00", rdy_s, bsy_s, wd_s);
    end
    repeat (4) @(negedge clk);
    total++;
    if (got.size() !== n || n !== 3) begin
      bad++; $display("FAIL rstmid_writes got=%0d want=3", got.size());
    end
    frame_exact(0, $urandom, "rstmid_new");
  endtask

  task automatic test_random;
    int s;
    logic [31:0] w;
    logic stalled_prev, done;
    logic [7:0] prev_wd;
    for (int it = 0; it < 10; it++) begin
      s = $urandom_range(0, 3);
      w = $urandom;
      got.delete(); exp.delete();
      expect_frame(s, w);
      @(posedge clk); #1;
      sel = s; data = w; valid[s] = 1'b1;
      @(posedge clk); #1;
      valid[s] = 1'b0;
      stalled_prev = 1'b0; prev_wd = 8'h00; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        full = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        if (stalled_prev) begin
          total++;
          if (wd_s !== prev_wd) begin
            bad++; $display("FAIL rand%0d hold got=%h want=%h", it, wd_s, prev_wd);
          end
        end
        stalled_prev = bsy_s && full;
        prev_wd = wd_s;
        if (!bsy_s) done = 1'b1;
        @(posedge clk); #1;
      end
      full = 1'b0;
      total++;
      if (!done) begin bad++; $display("FAIL rand%0d timeout got=busy want=idle", it); end
      compare_stream($sformatf("rand%0d", it));
    end
  endtask

  initial begin
    test_reset();
    frame_exact(0, 32'h12345678, "basic");
    frame_exact(1, 32'h12345678, "lsb_first");
    frame_exact(2, 32'h12345678, "no_checksum");
    frame_exact(3, {24'h0, 8'(($urandom_range(0, 255)))}, "single_byte");
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    total++;
    if (stray !== 0) begin bad++; $display("FAIL stray_writes got=%0d want=0", stray); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
